// File: rtl/md_pkg.sv
// md_pkg: shared op codes, FSM states and default latencies for the multiply/divide unit
package md_pkg;
  typedef enum logic [2:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO} md_op_e;
  typedef enum logic {MD_IDLE, MD_RUN} md_state_e;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;
  function automatic logic md_is_long(input md_op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction
endpackage

// File: rtl/md_op_encode.sv
// md_op_encode: folds decoder one-hots into a start strobe and an op code
module md_op_encode
  import md_pkg::*;
(
  input  logic   mult,
  input  logic   multu,
  input  logic   div,
  input  logic   divu,
  input  logic   mthi,
  input  logic   mtlo,
  output logic   start_raw,
  output md_op_e op
);
  // Any one-hot set means a legal MD op; lowest op code wins if several are set
  always_comb begin
    start_raw = mult | multu | div | divu | mthi | mtlo;
    op = mult ? MD_MULT : multu ? MD_MULTU : div ? MD_DIV : divu ? MD_DIVU : mthi ? MD_MTHI : MD_MTLO;
  end
endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: sequences mult/div latency, commits HI/LO and requests D-stage stalls
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  md_state_e state, state_n;
  md_op_e op_v;
  logic start_v, long_op, accept;
  logic [CW-1:0] count;
  logic [31:0] pend_hi, pend_lo, q_s, r_s, q_u, r_u;
  logic [63:0] prod_s, prod_u, res;
  md_op_encode u_enc (
    .mult(start && op == MD_MULT),
    .multu(start && op == MD_MULTU),
    .div(start && op == MD_DIV),
    .divu(start && op == MD_DIVU),
    .mthi(start && op == MD_MTHI),
    .mtlo(start && op == MD_MTLO),
    .start_raw(start_v),
    .op(op_v)
  );
  // Result is fixed at issue; divide-by-zero re-commits the current HI/LO
  always_comb begin
    long_op = md_is_long(op_v);
    accept = start_v & ~cancel & (state == MD_IDLE);
    busy = (state == MD_RUN);
    stall_req = md_in_d & (busy | (start_v & ~cancel & long_op));
    prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u = {32'h0, rs_val} * {32'h0, rt_val};
    q_s = $signed(rs_val) / $signed(rt_val);
    r_s = $signed(rs_val) % $signed(rt_val);
    q_u = rs_val / rt_val;
    r_u = rs_val % rt_val;
    res = op_v == MD_MULT ? prod_s : op_v == MD_MULTU ? prod_u : rt_val == 32'h0 ? {hi, lo} :
          op_v == MD_DIVU ? {r_u, q_u} :
          (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) ? {32'h0, 32'h8000_0000} : {r_s, q_s};
    state_n = state == MD_IDLE ? (accept && long_op ? MD_RUN : MD_IDLE) : (count == '0 ? MD_IDLE : MD_RUN);
  end
  // State, latency counter, pending result and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= MD_IDLE;
      count <= '0;
      hi <= '0;
      lo <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state <= state_n;
      if (accept && long_op) begin
        count <= op_v inside {MD_MULT, MD_MULTU} ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        {pend_hi, pend_lo} <= res;
      end else if (state == MD_RUN) begin
        if (count == '0) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end else begin
          count <= count - CW'(1);
        end
      end
      if (accept && op_v == MD_MTHI) hi <= rs_val;
      if (accept && op_v == MD_MTLO) lo <= rs_val;
    end
  end
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed checks of latency, arithmetic, stalls, cancel and reset abort
module tb_md_unit_ctrl;
  import md_pkg::*;
  logic clk = 0, resetn = 0, start = 0, cancel = 0, md_in_d = 0;
  logic [2:0] op = 0;
  logic [31:0] rs_val = 0, rt_val = 0;
  logic busy, stall_req;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0, n;
  md_unit_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .cancel(cancel), .md_in_d(md_in_d), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input md_op_e o, input logic [31:0] a, input logic [31:0] b, output int cyc);
    start = 1;
    op = o;
    rs_val = a;
    rt_val = b;
    adv();
    start = 0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      adv();
    end
  endtask
  // The hazard unit must never issue while an op is in flight
  always @(posedge clk) if (resetn && busy && start) chk("start_in_run", 1, 0);
  initial begin
    adv();
    adv();
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    resetn = 1;
    run_op(MD_MULT, 32'hFFFF_FFFF, 2, n);
    chk("mult_cyc", n, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 2, n);
    chk("multu_cyc", n, 5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    run_op(MD_DIV, -32'sd7, 2, n);
    chk("div_cyc", n, 10);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    run_op(MD_DIVU, 32'd100, 0, n);
    chk("div0_cyc", n, 10);
    chk("div0_hi", hi, 32'hFFFF_FFFF);
    chk("div0_lo", lo, 32'hFFFF_FFFD);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("ovf_hi", hi, 0);
    chk("ovf_lo", lo, 32'h8000_0000);
    run_op(MD_DIVU, 32'hFFFF_FFF0, 32'd7, n);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'h2492_4922);
    md_in_d = 1;
    start = 1;
    cancel = 1;
    op = MD_DIV;
    #1;
    chk("stall_cancel", stall_req, 0);
    cancel = 0;
    rs_val = 100;
    rt_val = 7;
    #1;
    chk("stall_issue", stall_req, 1);
    adv();
    start = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (stall_req && busy) n++;
      adv();
    end
    chk("stall_cycles", n, 10);
    chk("stall_end", stall_req, 0);
    chk("stall_lo", lo, 32'd14);
    chk("stall_hi", hi, 32'd2);
    md_in_d = 0;
    start = 1;
    cancel = 1;
    op = MD_MTHI;
    rs_val = 32'h1234;
    adv();
    start = 0;
    cancel = 0;
    chk("mthi_cancel_hi", hi, 32'd2);
    chk("mthi_cancel_busy", busy, 0);
    start = 1;
    adv();
    start = 0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", busy, 0);
    start = 1;
    op = MD_MTLO;
    rs_val = 32'h5678;
    adv();
    start = 0;
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_hi", hi, 32'h1234);
    start = 1;
    op = MD_MULT;
    rs_val = 3;
    rt_val = 4;
    adv();
    start = 0;
    chk("abort_busy1", busy, 1);
    adv();
    adv();
    resetn = 0;
    adv();
    resetn = 1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    repeat (8) adv();
    chk("abort_late_hi", hi, 0);
    chk("abort_late_lo", lo, 0);
    chk("abort_late_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
